// File: rtl/puzzle_board_ctrl.sv
// 15-puzzle board controller: owns the 4x4 tile store, shuffles it with an LFSR,
// validates and applies player moves, and scans the board for the solved layout.
//
// state   | meaning
// IDLE    | after reset, waiting for new_game
// SHUFFLE | one random blank-move attempt per cycle until the counter empties
// PLAY    | waiting for sel_pulse
// CHECK   | adjacency test of the latched cell against the blank
// SWAP    | move tile into the blank, bump move_cnt
// VERIFY  | compare one cell per cycle against the solved layout
// DONE    | board frozen, solved held high
module puzzle_board_ctrl #(
  parameter int          SHUFFLE_MOVES = 200,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic [4:0] cursor_addr,
  input  logic       sel_pulse,
  input  logic       new_game,
  input  logic [3:0] disp_addr,
  output logic [3:0] disp_tile,
  output logic [3:0] blank_pos,
  output logic [9:0] move_cnt,
  output logic       busy,
  output logic       illegal,
  output logic       solved
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SHUFFLE = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_SWAP    = 3'd4;
  localparam logic [2:0] ST_VERIFY  = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  logic [2:0]  state;
  logic [3:0]  board [16];
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [15:0] shuf_cnt;
  logic [3:0]  sel_idx;
  logic        sel_ok;
  logic [3:0]  vidx;
  logic [3:0]  shuf_tgt;
  logic        shuf_ok;
  logic        move_legal;

  function automatic logic adj2(input logic [1:0] a, input logic [1:0] b);
    return (({1'b0, a} + 3'd1) == {1'b0, b}) || (({1'b0, b} + 3'd1) == {1'b0, a});
  endfunction

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    shuf_tgt = blank_pos;
    shuf_ok  = 1'b0;
    case (lfsr[1:0])
      2'd0: begin shuf_ok = (blank_pos[3:2] != 2'd3); shuf_tgt = blank_pos + 4'd4; end
      2'd1: begin shuf_ok = (blank_pos[3:2] != 2'd0); shuf_tgt = blank_pos - 4'd4; end
      2'd2: begin shuf_ok = (blank_pos[1:0] != 2'd0); shuf_tgt = blank_pos - 4'd1; end
      default: begin shuf_ok = (blank_pos[1:0] != 2'd3); shuf_tgt = blank_pos + 4'd1; end
    endcase
  end

  always_comb begin
    move_legal = sel_ok &&
      (((sel_idx[3:2] == blank_pos[3:2]) && adj2(sel_idx[1:0], blank_pos[1:0])) ||
       ((sel_idx[1:0] == blank_pos[1:0]) && adj2(sel_idx[3:2], blank_pos[3:2])));
  end

  assign busy   = (state == ST_SHUFFLE) || (state == ST_CHECK) ||
                  (state == ST_SWAP) || (state == ST_VERIFY);
  assign solved = (state == ST_DONE);

  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      for (int i = 0; i < 16; i++) board[i] <= 4'(i + 1);
      lfsr      <= LFSR_SEED;
      shuf_cnt  <= '0;
      sel_idx   <= '0;
      sel_ok    <= 1'b0;
      vidx      <= '0;
      blank_pos <= 4'd15;
      move_cnt  <= '0;
      disp_tile <= '0;
      illegal   <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb};
      disp_tile <= board[disp_addr];
      illegal   <= 1'b0;
      if (new_game) begin
        // solved value of cell i is i+1 mod 16, which also gives 0 for cell 15
        for (int i = 0; i < 16; i++) board[i] <= 4'(i + 1);
        blank_pos <= 4'd15;
        move_cnt  <= '0;
        shuf_cnt  <= 16'(SHUFFLE_MOVES);
        state     <= (SHUFFLE_MOVES == 0) ? ST_PLAY : ST_SHUFFLE;
      end else begin
        case (state)
          ST_SHUFFLE: begin
            if (shuf_ok) begin
              board[blank_pos] <= board[shuf_tgt];
              board[shuf_tgt]  <= 4'd0;
              blank_pos        <= shuf_tgt;
              shuf_cnt         <= shuf_cnt - 16'd1;
              if (shuf_cnt == 16'd1) state <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (sel_pulse) begin
              sel_idx <= 4'(cursor_addr - 5'd1);
              sel_ok  <= (cursor_addr >= 5'd1) && (cursor_addr <= 5'd16);
              state   <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (move_legal) begin
              state <= ST_SWAP;
            end else begin
              illegal <= 1'b1;
              state   <= ST_PLAY;
            end
          end
          ST_SWAP: begin
            board[blank_pos] <= board[sel_idx];
            board[sel_idx]   <= 4'd0;
            blank_pos        <= sel_idx;
            if (move_cnt != 10'd999) move_cnt <= move_cnt + 10'd1;
            vidx  <= '0;
            state <= ST_VERIFY;
          end
          ST_VERIFY: begin
            if (board[vidx] != vidx + 4'd1) state <= ST_PLAY;
            else if (vidx == 4'd15)          state <= ST_DONE;
            else                             vidx  <= vidx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
